// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - op codes, engine states and sizing helper for shift_reg_engine
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_CLR  = 3'd6,
    OP_RSVD = 3'd7
  } shift_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } eng_state_e;

  // Step-count width able to express a full rotation of width/lanes steps.
  function automatic int cnt_width(input int width, input int lanes);
    return $clog2(width / lanes) + 1;
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational next register value for one engine step
module shift_step_unit
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] prl_in,
  input  logic [LANES-1:0] srl_in_lo,
  input  logic [LANES-1:0] srl_in_hi,
  output logic [WIDTH-1:0] nxt
);

  // One step moves LANES bits; NOP and the reserved code hold the value.
  always_comb begin
    nxt = data;
    case (op)
      OP_LOAD: nxt = prl_in;
      OP_SHL:  nxt = {data[WIDTH-1-LANES:0], srl_in_lo};
      OP_SHR:  nxt = {srl_in_hi, data[WIDTH-1:LANES]};
      OP_ROL:  nxt = {data[WIDTH-1-LANES:0], data[WIDTH-1 -: LANES]};
      OP_ROR:  nxt = {data[LANES-1:0], data[WIDTH-1:LANES]};
      OP_CLR:  nxt = RESET_VAL;
      default: nxt = data;
    endcase
  end

endmodule

// File: rtl/shift_reg_engine.sv
// rtl/shift_reg_engine.sv - command-driven multi-step shift/rotate register (optional SHIFT_REG_ABORT_EN)
module shift_reg_engine
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = cnt_width(WIDTH, LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_REG_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] prl_in,
  input  logic [LANES-1:0] srl_in_lo,
  input  logic [LANES-1:0] srl_in_hi,
  output logic [WIDTH-1:0] prl_out,
  output logic [LANES-1:0] srl_out_hi,
  output logic [LANES-1:0] srl_out_lo,
  output logic             busy,
  output logic             done
);

  if (LANES < 1 || LANES >= WIDTH) begin : g_bad_lanes
    $error("shift_reg_engine: LANES must satisfy 1 <= LANES < WIDTH");
  end
  if (WIDTH % LANES != 0) begin : g_bad_width
    $error("shift_reg_engine: WIDTH must be a multiple of LANES");
  end
  if ((WIDTH / LANES) >= (1 << CNT_W)) begin : g_bad_cnt
    $error("shift_reg_engine: CNT_W too narrow for a full rotation");
  end

  eng_state_e       state_q, state_d;
  shift_op_e        op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  logic             multi_step;
  logic             abort_hit;

  shift_step_unit #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .RESET_VAL (RESET_VAL)
  ) u_step (
    .op        (op_q),
    .data      (data_q),
    .prl_in    (prl_in),
    .srl_in_lo (srl_in_lo),
    .srl_in_hi (srl_in_hi),
    .nxt       (step_val)
  );

  // Only shifts and rotates honour the step count; everything else is one step.
  assign multi_step = (op_q == OP_SHL) || (op_q == OP_SHR) ||
                      (op_q == OP_ROL) || (op_q == OP_ROR);

`ifdef SHIFT_REG_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit = abort;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state logic: accept in IDLE, step or finish in RUN; done is registered
  // on the completing edge so it coincides with the final register value.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef SHIFT_REG_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = shift_op_e'(cmd_op);
          cnt_d   = cmd_cnt;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef SHIFT_REG_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (multi_step) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            data_d = step_val;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          data_d  = step_val;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and data registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      data_q  <= RESET_VAL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

`ifdef SHIFT_REG_ABORT_EN
  // Abort indication pulses alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end
`endif

  assign cmd_ready  = (state_q == IDLE) && rst_n;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign prl_out    = data_q;
  assign srl_out_hi = data_q[WIDTH-1 -: LANES];
  assign srl_out_lo = data_q[LANES-1:0];

endmodule

// File: tb/tb_shift_reg_engine.sv
// tb/tb_shift_reg_engine.sv - directed self-checking bench for shift_reg_engine
module tb_shift_reg_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         failures = 0;

  // DUT 1: WIDTH=8, LANES=1
  logic       cmd_valid, cmd_ready, busy, done;
  logic [2:0] cmd_op;
  logic [3:0] cmd_cnt;
  logic [7:0] prl_in, prl_out;
  logic       srl_in_lo, srl_in_hi, srl_out_hi, srl_out_lo;

  // DUT 2: WIDTH=8, LANES=2
  logic       c2_valid, c2_ready, busy2, done2;
  logic [2:0] c2_op;
  logic [2:0] c2_cnt;
  logic [7:0] prl_in2, prl_out2;
  logic [1:0] lo_in2, hi_in2, hi_out2, lo_out2;

`ifdef SHIFT_REG_ABORT_EN
  logic abort, aborted, abort2, aborted2;
`endif

  always #5 clk = ~clk;

  shift_reg_engine #(.WIDTH(8), .LANES(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHIFT_REG_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_cnt    (cmd_cnt),
    .prl_in     (prl_in),
    .srl_in_lo  (srl_in_lo),
    .srl_in_hi  (srl_in_hi),
    .prl_out    (prl_out),
    .srl_out_hi (srl_out_hi),
    .srl_out_lo (srl_out_lo),
    .busy       (busy),
    .done       (done)
  );

  shift_reg_engine #(.WIDTH(8), .LANES(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHIFT_REG_ABORT_EN
    .abort      (abort2),
    .aborted    (aborted2),
`endif
    .cmd_valid  (c2_valid),
    .cmd_ready  (c2_ready),
    .cmd_op     (c2_op),
    .cmd_cnt    (c2_cnt),
    .prl_in     (prl_in2),
    .srl_in_lo  (lo_in2),
    .srl_in_hi  (hi_in2),
    .prl_out    (prl_out2),
    .srl_out_hi (hi_out2),
    .srl_out_lo (lo_out2),
    .busy       (busy2),
    .done       (done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge (E0) on DUT 1.
  task automatic issue(input logic [2:0] op, input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic issue2(input logic [2:0] op, input logic [2:0] cnt);
    c2_valid = 1'b1;
    c2_op    = op;
    c2_cnt   = cnt;
    tick();
    c2_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 4'd0; prl_in = 8'h00;
    srl_in_lo = 1'b0; srl_in_hi = 1'b0;
    c2_valid = 1'b0; c2_op = 3'd0; c2_cnt = 3'd0; prl_in2 = 8'h00;
    lo_in2 = 2'b00; hi_in2 = 2'b00;
`ifdef SHIFT_REG_ABORT_EN
    abort = 1'b0; abort2 = 1'b0;
`endif

    // 1. Reset defaults
    tick(); tick();
    check("rst_prl_out", prl_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", cmd_ready, 1'b1);
    tick();

    // 2. LOAD 0xA5
    prl_in = 8'hA5;
    issue(3'd1, 4'd0);
    check("load_busy_e0", busy, 1'b1);
    check("load_ready_e0", cmd_ready, 1'b0);
    check("load_done_e0", done, 1'b0);
    tick();
    check("load_prl_e1", prl_out, 8'hA5);
    check("load_done_e1", done, 1'b1);
    check("load_busy_e1", busy, 1'b0);
    tick();
    check("load_done_clr", done, 1'b0);

    // 3. ROL cnt=3
    issue(3'd4, 4'd3);
    tick();
    check("rol_e1", prl_out, 8'h4B);
    check("rol_done_e1", done, 1'b0);
    tick();
    check("rol_e2", prl_out, 8'h96);
    check("rol_done_e2", done, 1'b0);
    tick();
    check("rol_e3", prl_out, 8'h2D);
    check("rol_done_e3", done, 1'b1);
    tick();

    // 4. SHL cnt=4 with srl_in_lo=1
    srl_in_lo = 1'b1;
    issue(3'd2, 4'd4);
    tick();
    check("shl_e1", prl_out, 8'h5B);
    check("shl_hi_e1", srl_out_hi, 1'b0);
    tick();
    check("shl_e2", prl_out, 8'hB7);
    check("shl_hi_e2", srl_out_hi, 1'b1);
    tick();
    check("shl_e3", prl_out, 8'h6F);
    check("shl_hi_e3", srl_out_hi, 1'b0);
    tick();
    check("shl_e4", prl_out, 8'hDF);
    check("shl_hi_e4", srl_out_hi, 1'b1);
    check("shl_done_e4", done, 1'b1);
    check("shl_lo_e4", srl_out_lo, 1'b1);
    srl_in_lo = 1'b0;
    tick();

    // 5a. SHR cnt=0 with cmd_valid held: second acceptance only in done cycle
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 4'd0;
    tick();
    check("shr0_busy_e0", busy, 1'b1);
    check("shr0_ready_e0", cmd_ready, 1'b0);
    tick();
    check("shr0_done_e1", done, 1'b1);
    check("shr0_busy_e1", busy, 1'b0);
    check("shr0_ready_e1", cmd_ready, 1'b1);
    check("shr0_prl_e1", prl_out, 8'hDF);
    tick();
    check("shr0_rebusy", busy, 1'b1);
    check("shr0_redone", done, 1'b0);
    cmd_valid = 1'b0;
    tick();
    check("shr0_redone2", done, 1'b1);
    check("shr0_prl2", prl_out, 8'hDF);
    tick();

    // Reserved op behaves as NOP and completes at E1
    cmd_cnt = 4'd5;
    issue(3'd7, 4'd5);
    tick();
    check("rsvd_done", done, 1'b1);
    check("rsvd_prl", prl_out, 8'hDF);
    tick();

    // 5b. LANES=2: SHR cnt=2 from 0xF0 with srl_in_hi=01
    prl_in2 = 8'hF0;
    issue2(3'd1, 3'd0);
    tick();
    check("l2_load", prl_out2, 8'hF0);
    tick();
    hi_in2 = 2'b01;
    issue2(3'd3, 3'd2);
    tick();
    check("l2_shr_e1", prl_out2, 8'h7C);
    check("l2_done_e1", done2, 1'b0);
    tick();
    check("l2_shr_e2", prl_out2, 8'h5F);
    check("l2_done_e2", done2, 1'b1);
    check("l2_lo_out", lo_out2, 2'b11);
    check("l2_hi_out", hi_out2, 2'b01);
    tick();

    // CLR returns to reset value
    issue(3'd6, 4'd0);
    tick();
    check("clr_prl", prl_out, 8'h00);
    check("clr_done", done, 1'b1);
    tick();

`ifdef SHIFT_REG_ABORT_EN
    // 6b. Abort at E3 of ROR keeps the E2 value
    prl_in = 8'h81;
    issue(3'd1, 4'd0);
    tick(); tick();
    issue(3'd5, 4'd8);
    tick();
    check("ab_ror_e1", prl_out, 8'hC0);
    tick();
    check("ab_ror_e2", prl_out, 8'h60);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_prl", prl_out, 8'h60);
    check("ab_done", done, 1'b1);
    check("ab_aborted", aborted, 1'b1);
    check("ab_busy", busy, 1'b0);
    tick();
    check("ab_aborted_clr", aborted, 1'b0);
`endif

    // 6. ROR cnt=8 from 0x81, reset after E3
    prl_in = 8'h81;
    issue(3'd1, 4'd0);
    tick(); tick();
    issue(3'd5, 4'd8);
    tick();
    check("ror_e1", prl_out, 8'hC0);
    tick();
    check("ror_e2", prl_out, 8'h60);
    tick();
    check("ror_e3", prl_out, 8'h30);
    check("ror_busy_e3", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ror_rst_prl", prl_out, 8'h00);
    check("ror_rst_busy", busy, 1'b0);
    check("ror_rst_ready", cmd_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ror_no_done1", done, 1'b0);
    check("ror_idle", busy, 1'b0);
    tick();
    check("ror_no_done2", done, 1'b0);
    check("ror_prl_after", prl_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
